// File: rtl/ctr_seq.sv
// rtl/ctr_seq.sv - mode-driven up/down/reload/ping-pong counter sequencer
module ctr_seq #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         stop,
    input  logic [1:0]   mode,
    input  logic [N-1:0] limit,
    output logic [N-1:0] ctr_out,
    output logic         up_dwn_b,
    output logic         busy,
    output logic         tick,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNT_UP = 2'd1,
        COUNT_DN = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [1:0]   MODE_UP_ONCE = 2'b00;
    localparam logic [1:0]   MODE_DN_ONCE = 2'b01;
    localparam logic [1:0]   MODE_RELOAD  = 2'b10;
    localparam logic [1:0]   MODE_PINGPNG = 2'b11;
    localparam logic [N-1:0] ZERO         = '0;
    localparam logic [N-1:0] ONE          = {{(N-1){1'b0}}, 1'b1};

    state_t       state, state_nx;
    logic [N-1:0] ctr_nx;
    logic         up_nx;
    logic [1:0]   mode_q, mode_nx;
    logic [N-1:0] lim_q, lim_nx;

    // State, count, direction and latched configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ctr_out  <= ZERO;
            up_dwn_b <= 1'b1;
            mode_q   <= 2'b00;
            lim_q    <= ZERO;
        end else begin
            state    <= state_nx;
            ctr_out  <= ctr_nx;
            up_dwn_b <= up_nx;
            mode_q   <= mode_nx;
            lim_q    <= lim_nx;
        end
    end

    // Next-state, next-count and status outputs; stop outranks terminal handling
    always_comb begin
        state_nx = state;
        ctr_nx   = ctr_out;
        up_nx    = up_dwn_b;
        mode_nx  = mode_q;
        lim_nx   = lim_q;
        busy     = (state == COUNT_UP) || (state == COUNT_DN);
        done     = (state == DONE);
        tick     = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop) begin
                    mode_nx = mode;
                    lim_nx  = limit;
                    if (limit == ZERO) begin
                        // Nothing to count: report completion straight away
                        state_nx = DONE;
                        ctr_nx   = ZERO;
                        up_nx    = (mode != MODE_DN_ONCE);
                    end else if (mode == MODE_DN_ONCE) begin
                        state_nx = COUNT_DN;
                        ctr_nx   = limit;
                        up_nx    = 1'b0;
                    end else begin
                        state_nx = COUNT_UP;
                        ctr_nx   = ZERO;
                        up_nx    = 1'b1;
                    end
                end
            end

            COUNT_UP: begin
                tick = !stop && (ctr_out == lim_q);
                if (stop) begin
                    state_nx = IDLE;
                end else if (ctr_out == lim_q) begin
                    case (mode_q)
                        MODE_RELOAD: ctr_nx = ZERO;
                        MODE_PINGPNG: begin
                            state_nx = COUNT_DN;
                            ctr_nx   = lim_q - ONE;
                            up_nx    = 1'b0;
                        end
                        default: state_nx = DONE;
                    endcase
                end else begin
                    ctr_nx = ctr_out + ONE;
                end
            end

            COUNT_DN: begin
                tick = !stop && (ctr_out == ZERO);
                if (stop) begin
                    state_nx = IDLE;
                end else if (ctr_out == ZERO) begin
                    if (mode_q == MODE_PINGPNG) begin
                        state_nx = COUNT_UP;
                        ctr_nx   = ONE;
                        up_nx    = 1'b1;
                    end else begin
                        state_nx = DONE;
                    end
                end else begin
                    ctr_nx = ctr_out - ONE;
                end
            end

            DONE: state_nx = IDLE;

            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ctr_seq.sv
// tb/tb_ctr_seq.sv - scoreboard-driven directed bench for ctr_seq
module tb_ctr_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [2:0] limit;
    logic [2:0] ctr_out;
    logic       up_dwn_b;
    logic       busy;
    logic       tick;
    logic       done;

    int total = 0;
    int bad   = 0;

    // {ctr_out, up_dwn_b, busy, tick, done}
    logic [6:0] exp_q[$];

    ctr_seq #(.N(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .limit    (limit),
        .ctr_out  (ctr_out),
        .up_dwn_b (up_dwn_b),
        .busy     (busy),
        .tick     (tick),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pack(input logic [2:0] c, input logic u,
                                        input logic b, input logic t, input logic d);
        return {c, u, b, t, d};
    endfunction

    task automatic exp(input logic [2:0] c, input logic u, input logic b,
                       input logic t, input logic d);
        exp_q.push_back(pack(c, u, b, t, d));
    endtask

    task automatic step(input string tag);
        logic [6:0] obs;
        logic [6:0] e;
        @(posedge clk);
        #1;
        obs = {ctr_out, up_dwn_b, busy, tick, done};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty obs=%b", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s obs={ctr,up,busy,tick,done}=%b exp=%b", tag, obs, e);
            end
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    task automatic check_reset(input string tag);
        logic [6:0] obs;
        obs = {ctr_out, up_dwn_b, busy, tick, done};
        total++;
        assert (obs === 7'b000_1_0_0_0) else begin
            bad++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, 7'b000_1_0_0_0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        mode  = 2'b00;
        limit = 3'd0;
        #12;
        check_reset("reset_state");
        @(negedge clk);
        rst_n = 1'b1;
        exp(3'd0, 1, 0, 0, 0);
        step("idle_after_reset");

        // one-shot up, L=5; config changes and start pulses while busy are ignored
        start = 1'b1; mode = 2'b00; limit = 3'd5;
        for (int v = 0; v <= 5; v++) exp(3'(v), 1, 1, (v == 5), 0);
        exp(3'd5, 1, 0, 0, 1);
        exp(3'd5, 1, 0, 0, 0);
        step("up_once");
        start = 1'b0; mode = 2'b11; limit = 3'd2;
        step("up_once");
        start = 1'b1;
        step("up_once_start_busy");
        start = 1'b0;
        run(5, "up_once");

        // one-shot down, L=3
        start = 1'b1; mode = 2'b01; limit = 3'd3;
        exp(3'd3, 0, 1, 0, 0);
        exp(3'd2, 0, 1, 0, 0);
        exp(3'd1, 0, 1, 0, 0);
        exp(3'd0, 0, 1, 1, 0);
        exp(3'd0, 0, 0, 0, 1);
        exp(3'd0, 0, 0, 0, 0);
        step("dn_once");
        start = 1'b0;
        run(5, "dn_once");

        // auto-reload, L=2, 9 cycles then stop
        start = 1'b1; mode = 2'b10; limit = 3'd2;
        for (int i = 0; i < 9; i++) exp(3'(i % 3), 1, 1, ((i % 3) == 2), 0);
        step("reload");
        start = 1'b0;
        run(8, "reload");
        stop = 1'b1;
        exp(3'd2, 1, 0, 0, 0);
        step("reload_stop");
        stop = 1'b0;

        // ping-pong, L=3, 11 cycles then stop
        start = 1'b1; mode = 2'b11; limit = 3'd3;
        exp(3'd0, 1, 1, 0, 0); exp(3'd1, 1, 1, 0, 0); exp(3'd2, 1, 1, 0, 0);
        exp(3'd3, 1, 1, 1, 0); exp(3'd2, 0, 1, 0, 0); exp(3'd1, 0, 1, 0, 0);
        exp(3'd0, 0, 1, 1, 0); exp(3'd1, 1, 1, 0, 0); exp(3'd2, 1, 1, 0, 0);
        exp(3'd3, 1, 1, 1, 0); exp(3'd2, 0, 1, 0, 0);
        step("pingpong");
        start = 1'b0;
        run(10, "pingpong");
        stop = 1'b1;
        exp(3'd2, 0, 0, 0, 0);
        step("pingpong_stop");
        stop = 1'b0;

        // one-shot up, L=7, stop with start at count 4, then start+stop in IDLE
        start = 1'b1; mode = 2'b00; limit = 3'd7;
        for (int v = 0; v <= 4; v++) exp(3'(v), 1, 1, 0, 0);
        step("stop_mid");
        start = 1'b0;
        run(4, "stop_mid");
        stop = 1'b1; start = 1'b1;
        exp(3'd4, 1, 0, 0, 0);
        exp(3'd4, 1, 0, 0, 0);
        run(2, "stop_start_nop");
        stop = 1'b0; start = 1'b0;
        exp(3'd4, 1, 0, 0, 0);
        step("stop_idle");

        // L=0: straight to DONE
        start = 1'b1; mode = 2'b00; limit = 3'd0;
        exp(3'd0, 1, 0, 0, 1);
        exp(3'd0, 1, 0, 0, 0);
        step("l_zero");
        start = 1'b0;
        step("l_zero");

        // asynchronous reset mid-count in auto-reload
        start = 1'b1; mode = 2'b10; limit = 3'd3;
        exp(3'd0, 1, 1, 0, 0);
        exp(3'd1, 1, 1, 0, 0);
        exp(3'd2, 1, 1, 0, 0);
        step("pre_reset");
        start = 1'b0;
        run(2, "pre_reset");
        #2;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        exp(3'd0, 1, 0, 0, 0);
        exp(3'd0, 1, 0, 0, 0);
        run(2, "idle_no_resume");

        // ping-pong, L=1 alternates 0,1
        start = 1'b1; mode = 2'b11; limit = 3'd1;
        exp(3'd0, 1, 1, 0, 0);
        exp(3'd1, 1, 1, 1, 0);
        exp(3'd0, 0, 1, 1, 0);
        exp(3'd1, 1, 1, 1, 0);
        exp(3'd0, 0, 1, 1, 0);
        step("pingpong_l1");
        start = 1'b0;
        run(4, "pingpong_l1");

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ctr_seq.md
CTR_SEQ -- requirements
Module: ctr_seq

Interface
REQ-001 SHALL have parameter N, default 3: counter width in bits, N >= 2.
REQ-002 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1: request to begin a sequence, sampled only in IDLE.
REQ-005 SHALL have port stop  input  1: abort request, sampled every cycle.
REQ-006 SHALL have port mode  input  2: 00 one-shot up, 01 one-shot down, 10 auto-reload up, 11 ping-pong.
REQ-007 SHALL have port limit  input  N: terminal count L, unsigned.
REQ-008 SHALL have port ctr_out  output  N: current count, registered.
REQ-009 SHALL have port up_dwn_b  output  1: current direction, 1 = up, 0 = down, registered.
REQ-010 SHALL have port busy  output  1: high in COUNT_UP and COUNT_DN.
REQ-011 SHALL have port tick  output  1: high for exactly the cycles in which ctr_out holds the terminal value of the active direction while busy.
REQ-012 SHALL have port done  output  1: one-cycle pulse in state DONE.

Function
REQ-013 SHALL implement the FSM states IDLE, COUNT_UP, COUNT_DN and DONE.
REQ-014 SHALL, in IDLE with start=1 and stop=0, latch mode and limit into internal registers.
REQ-015 SHALL, in the same IDLE start cycle, load ctr_out with 0 and go to COUNT_UP for modes 00/10/11, or load it with L and go to COUNT_DN for mode 01.
REQ-016 SHALL, in the same IDLE start cycle, set up_dwn_b to match the entered state.
REQ-017 SHALL, when the latched L = 0, go from IDLE straight to DONE without counting, with ctr_out = 0 and tick never asserted.
REQ-018 SHALL, in COUNT_UP, increment ctr_out by 1 per cycle; terminal value = L.
REQ-019 SHALL, in COUNT_DN, decrement ctr_out by 1 per cycle; terminal value = 0.
REQ-020 SHALL, at the COUNT_UP terminal, act by mode: 00 -> DONE with ctr_out held at L; 10 -> ctr_out = 0, stay in COUNT_UP; 11 -> COUNT_DN, ctr_out = L-1, up_dwn_b = 0.
REQ-021 SHALL, at the COUNT_DN terminal, act by mode: 01 -> DONE with ctr_out held at 0; 11 -> COUNT_UP, ctr_out = 1, up_dwn_b = 1.
REQ-022 SHALL go from DONE to IDLE after one cycle and keep ctr_out at its final value until the next start.
REQ-023 SHALL keep ctr_out within 0..L at all times; the arithmetic never wraps modulo 2^N.
REQ-024 SHALL ignore start while busy or in DONE, and ignore changes to mode/limit after the latch.
REQ-025 SHALL, on stop=1 in COUNT_UP/COUNT_DN, go to IDLE next cycle with ctr_out frozen, no done pulse and no tick that cycle; stop takes priority over terminal handling.
REQ-026 SHALL treat start=1 with stop=1 in IDLE as no operation.
REQ-027 SHALL meet these timings with start sampled at edge 0: one-shot up gives ctr_out = 0 at cycle 1, L at cycle 1+L with tick=1, done at cycle 2+L, and IDLE at cycle 3+L.
REQ-028 SHALL meet these periods: auto-reload = L+1 cycles; ping-pong = 2L cycles (for L=1 the sequence alternates 0,1).

Reset
REQ-029 SHALL, on rst_n=0 and regardless of clk, force state = IDLE, ctr_out = 0, up_dwn_b = 1, busy = 0, tick = 0, done = 0, and clear the latched mode/limit.
REQ-030 SHALL, when reset occurs mid-sequence, abort it with no done pulse, and resume operation only on a start after rst_n returns high.

Verification
REQ-031 SHALL pass: N=3, mode 00, L=5, start pulse -> ctr_out 0..5 on cycles 1..6, tick on cycle 6, done on cycle 7, busy low from cycle 7.
REQ-032 SHALL pass: mode 01, L=3 -> ctr_out 3,2,1,0, tick when 0, done one cycle later, final ctr_out = 0.
REQ-033 SHALL pass: mode 10, L=2, run 9 cycles -> 0,1,2,0,1,2,0,1,2, tick every 3rd cycle, done never asserted.
REQ-034 SHALL pass: mode 11, L=3 -> 0,1,2,3,2,1,0,1,..., up_dwn_b toggling after each terminal, tick when 3 and when 0.
REQ-035 SHALL pass: mode 00, L=7, stop asserted when ctr_out=4 -> IDLE next cycle, ctr_out stays 4, no done; a start in the same cycle as stop is ignored.
REQ-036 SHALL pass: L=0 start -> done at cycle 1 with busy never high; rst_n pulsed low mid-count in mode 10 -> all outputs at reset values immediately.
